// File: rtl/timeout_counter_param.sv
// rtl/timeout_counter_param.sv - programmable prescaled timeout counter with one-shot/periodic modes
module timeout_counter_param #(
  parameter int CNT_W      = 8,
  parameter int DEFAULT_TC = 9,
  parameter int PRE_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cnt_en,
  input  logic             periodic,
  input  logic             tc_load,
  input  logic [CNT_W-1:0] tc_in,
  input  logic [PRE_W-1:0] prescale,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             timeout,
  output logic             timeout_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt, tc_reg, tc_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic             pulse_nxt;
  logic             tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      pre           <= '0;
      tc_reg        <= CNT_W'(DEFAULT_TC);
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      pre           <= pre_nxt;
      tc_reg        <= tc_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pre_nxt   = pre;
    tc_nxt    = tc_reg;
    pulse_nxt = 1'b0;
    tick      = 1'b0;

    // TC is only writable while idle so a run never sees its terminal count move.
    if (state == IDLE && tc_load)
      tc_nxt = tc_in;

    if (abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
      pre_nxt   = '0;
    end else if (start) begin
      state_nxt = RUN;
      count_nxt = '0;
      pre_nxt   = '0;
    end else if (state == RUN && cnt_en) begin
      // >= rather than == so a prescale lowered mid-run ticks at once instead of wrapping.
      if (pre >= prescale) begin
        tick    = 1'b1;
        pre_nxt = '0;
      end else begin
        pre_nxt = pre + 1'b1;
      end
      if (tick) begin
        if (count == tc_reg) begin
          count_nxt = '0;
          pulse_nxt = 1'b1;
          if (!periodic)
            state_nxt = DONE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
    end
  end

  assign busy    = (state == RUN);
  assign timeout = (state == DONE);

endmodule

// File: tb/tb_timeout_counter_param.sv
// tb/tb_timeout_counter_param.sv - directed bench with cycle model for timeout_counter_param
module tb_timeout_counter_param;

  logic       clk = 1'b0;
  logic       rst, start, abort, cnt_en, periodic, tc_load;
  logic [7:0] tc_in;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       busy, timeout, timeout_pulse;

  int tests = 0;
  int fails = 0;

  timeout_counter_param #(.CNT_W(8), .DEFAULT_TC(9), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cnt_en(cnt_en),
    .periodic(periodic), .tc_load(tc_load), .tc_in(tc_in), .prescale(prescale),
    .count(count), .busy(busy), .timeout(timeout), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Model: a run is described by enabled cycles since start; expiries fall on multiples
  // of (tc+1)*(prescale+1) and the visible count is the tick number modulo tc+1.
  bit m_run, m_done, m_pulse;
  int m_tc, m_en, m_period;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_done = 0; m_pulse = 0; m_tc = 9; m_en = 0;
    end else begin
      m_pulse = 0;
      if (!m_run && !m_done && tc_load) m_tc = int'(tc_in);
      if (abort) begin
        m_run = 0; m_done = 0; m_en = 0;
      end else if (start) begin
        m_run = 1; m_done = 0; m_en = 0;
      end else if (m_run && cnt_en) begin
        m_en = m_en + 1;
        m_period = (m_tc + 1) * (int'(prescale) + 1);
        if (m_en % m_period == 0) begin
          m_pulse = 1;
          if (!periodic) begin
            m_run = 0; m_done = 1;
          end
        end
      end
    end
  end

  function automatic int exp_count();
    if (!m_run) return 0;
    return (m_en / (int'(prescale) + 1)) % (m_tc + 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("model_count", int'(count), exp_count());
      check("model_busy", int'(busy), int'(m_run));
      check("model_timeout", int'(timeout), int'(m_done));
      check("model_pulse", int'(timeout_pulse), int'(m_pulse));
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input bit load, input logic [7:0] tcv);
    start = 1'b1; tc_load = load; tc_in = tcv;
    cycle();
    start = 1'b0; tc_load = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  task automatic load_tc(input logic [7:0] tcv);
    tc_load = 1'b1; tc_in = tcv;
    cycle();
    tc_load = 1'b0;
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (timeout_pulse) begin
        n = i;
        return;
      end
    end
  endtask

  int n, np;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; cnt_en = 1'b0;
    periodic = 1'b0; tc_load = 1'b0; tc_in = '0; prescale = '0;
    #12;
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_pulse", int'(timeout_pulse), 0);
    @(negedge clk);
    rst = 1'b1;

    // legacy 10-tick one-shot
    cnt_en = 1'b1;
    do_start(1'b0, 8'd0);
    wait_pulse(50, n);
    check("legacy_latency", n, 10);
    check("legacy_timeout", int'(timeout), 1);
    check("legacy_busy", int'(busy), 0);
    repeat (3) cycle();
    check("legacy_timeout_held", int'(timeout), 1);
    check("legacy_count_done", int'(count), 0);

    // periodic, TC=3 loaded with start, prescale=2
    do_abort();
    prescale = 4'd2; periodic = 1'b1;
    do_start(1'b1, 8'd3);
    np = 0;
    repeat (36) begin
      cycle();
      if (timeout_pulse) np++;
    end
    check("periodic_pulses", np, 3);
    check("periodic_busy", int'(busy), 1);
    check("periodic_timeout", int'(timeout), 0);

    // freeze with cnt_en low for 5 cycles at count=4
    do_abort();
    prescale = 4'd0; periodic = 1'b0;
    do_start(1'b1, 8'd9);
    repeat (4) cycle();
    check("freeze_at4", int'(count), 4);
    cnt_en = 1'b0;
    repeat (5) cycle();
    check("freeze_hold", int'(count), 4);
    cnt_en = 1'b1;
    wait_pulse(50, n);
    check("freeze_latency", (n < 0) ? -1 : 9 + n, 15);

    // abort beats start; tc_load in RUN ignored
    do_start(1'b0, 8'd0);
    repeat (3) cycle();
    abort = 1'b1; start = 1'b1;
    cycle();
    abort = 1'b0; start = 1'b0;
    check("prio_busy", int'(busy), 0);
    check("prio_count", int'(count), 0);
    do_start(1'b0, 8'd0);
    load_tc(8'd5);
    wait_pulse(50, n);
    check("run_tcload_ignored", (n < 0) ? -1 : 1 + n, 10);
    do_start(1'b0, 8'd0);
    wait_pulse(50, n);
    check("next_run_tc9", n, 10);

    // TC=0 boundary, periodic every enabled cycle, then restart from DONE
    do_abort();
    load_tc(8'd0);
    periodic = 1'b1;
    do_start(1'b0, 8'd0);
    np = 0;
    repeat (8) begin
      cycle();
      if (timeout_pulse) np++;
    end
    check("tc0_pulses", np, 8);
    periodic = 1'b0;
    cycle();
    check("tc0_done", int'(timeout), 1);
    do_start(1'b0, 8'd0);
    check("restart_busy", int'(busy), 1);
    check("restart_count", int'(count), 0);
    check("restart_timeout", int'(timeout), 0);

    // asynchronous reset mid-run restores DEFAULT_TC
    do_abort();
    load_tc(8'd3);
    do_start(1'b0, 8'd0);
    repeat (2) cycle();
    #2 rst = 1'b0;
    #1;
    check("areset_count", int'(count), 0);
    check("areset_busy", int'(busy), 0);
    check("areset_timeout", int'(timeout), 0);
    check("areset_pulse", int'(timeout_pulse), 0);
    @(negedge clk);
    rst = 1'b1;
    do_start(1'b0, 8'd0);
    wait_pulse(50, n);
    check("areset_default_tc", n, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
